pwconv_1point_mul8_issuer: RTL
==============================

Name: pwconv_1point_mul8_issuer

Overview:
- Producer side of the 8-input + bias point adder in the PWconv 1x1 path.
- Walks every (position, output channel) pair of a feature map and reads one 8-channel feature word and one 8-weight word per pair.
- Forms 8 signed products, sign-extended to 32 bits, and presents them with the channel bias and a one-cycle `en` strobe that the adder latches.

Parameters:
- NPOS, 16, number of feature-map positions (H*W).
- NOC, 4, number of output channels.
- PA_W, 4, feature address width (>= clog2(NPOS)).
- OA_W, 2, weight/bias address width (>= clog2(NOC)).

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, synchronous, active-low.
- start  in  1  begin one full pass; sampled only in IDLE.
- out_ready  in  1  downstream may accept a point this cycle; 0 freezes the pipeline.
- feat_addr  out  PA_W  feature memory address; sync read, data valid next cycle.
- feat_data  in  64  8 signed int8 channels, ch k at bits [8k+7:8k].
- w_addr  out  OA_W  weight/bias memory address; sync read, latency 1.
- w_data  in  64  8 signed int8 weights, same packing.
- bias_data  in  32  signed bias for w_addr, latency 1.
- data_in0..data_in7  out  32 each  signed product ch k, sign-extended.
- bias  out  32  registered bias for the current point.
- en  out  1  point valid strobe to the adder.
- pos_idx  out  PA_W  position tag of the current output.
- oc_idx  out  OA_W  output-channel tag of the current output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of a pass.

Behaviour:
- All state changes on posedge clk. When rst_b=0 at an edge:
  - state goes to IDLE; all counters and valid bits clear.
  - all outputs are 0: data_in*, bias, en, pos_idx, oc_idx, feat_addr, w_addr, busy, done.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when start=1. pos and oc counters are already 0.
  - RUN -> DRAIN when the last pair (pos=NPOS-1, oc=NOC-1) is issued with advance=1.
  - DRAIN -> DONE when both pipeline valid bits are 0.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - start is ignored outside IDLE.
- Advance signal: advance = out_ready.
- Pipeline:
  - Stage 0 (issue), RUN only: feat_addr=pos and w_addr=oc are driven registered. v1 <= 1 on advance.
  - Stage 1: memory data valid. Capture the stage-0 tags.
  - Stage 2 (output register): on advance, with v1=1:
    - data_ink <= sext32(feat[k]*w[k]), full signed 8x8 -> 16 product.
    - bias <= bias_data.
    - tags update.
    - v2 <= v1.
- Loop order: oc inner, pos outer, i.e. (0,0),(0,1)..(0,NOC-1),(1,0)... On the last pair, both counters wrap to 0.
- Output strobe: en = v2 & out_ready, registered so it lands with the data. Each pair produces exactly one en pulse. Latency from issue to en is 2 advancing cycles.
- Stall (out_ready=0):
  - Counters, addresses, valid bits and output registers hold.
  - en=0.
  - Addresses stay stable, so memory re-presents the same data and none is lost.
- Simultaneous events:
  - out_ready=0 on the last issue cycle: the RUN->DRAIN transition is delayed until advance.
  - Stall in DRAIN holds DRAIN.
- Reset mid-pass aborts immediately: no done pulse and no further en. The next start begins again at (0,0).
- No saturation is needed: the largest magnitude is -128*-128 = 16384.

Test Plan:
- Single pass, NPOS=2, NOC=2, out_ready=1:
  - Stimulus: all feat = 1, weights[oc] = oc+1, bias = 10*oc.
  - Required: 4 en pulses. Pairs in order (0,0),(0,1),(1,0),(1,1). Each data_ink = oc+1. done pulses once, 1 cycle after the last en.
- Signed extremes:
  - Stimulus: feat ch0 = -128, w ch0 = -128; feat ch1 = -128, w ch1 = 127.
  - Required: data_in0 = 32'sd16384, data_in1 = 32'hFFFF_C080 (-16256).
- Stall:
  - Stimulus: out_ready=0 for 3 cycles after the first en.
  - Required: no en during the stall; outputs and tags held; sequence resumes with no missing or duplicated pairs; total en count = NPOS*NOC.
- Start while busy:
  - Stimulus: pulse start mid-RUN.
  - Required: ignored; exactly one done; en count unchanged.
- Reset mid-pass:
  - Stimulus: rst_b=0 for 1 cycle after 3 en pulses.
  - Required: next edge has all outputs 0 and state IDLE, no done. A new start restarts from pos_idx=0, oc_idx=0.
- Back-to-back passes:
  - Stimulus: start in the first IDLE cycle after done.
  - Required: second pass is identical; counters start at 0.

Source files
------------

// File: rtl/pwconv_1point_mul8_issuer_if.sv
// Point bus from the issuer to the 8-input + bias adder.
// Handshake: the adder raises out_ready when it can take a point this cycle;
// the issuer raises en for exactly one cycle per point, and en is only ever
// high in a cycle that follows an edge where out_ready was 1. When out_ready
// is 0 the issuer freezes and en stays 0.
interface pwconv_1point_mul8_issuer_if #(
  parameter int PA_W = 4,
  parameter int OA_W = 2
);
  logic            out_ready;
  logic [31:0]     data_in0;
  logic [31:0]     data_in1;
  logic [31:0]     data_in2;
  logic [31:0]     data_in3;
  logic [31:0]     data_in4;
  logic [31:0]     data_in5;
  logic [31:0]     data_in6;
  logic [31:0]     data_in7;
  logic [31:0]     bias;
  logic            en;
  logic [PA_W-1:0] pos_idx;
  logic [OA_W-1:0] oc_idx;

  modport master (
    input  out_ready,
    output data_in0, data_in1, data_in2, data_in3,
    output data_in4, data_in5, data_in6, data_in7,
    output bias, en, pos_idx, oc_idx
  );

  modport slave (
    output out_ready,
    input  data_in0, data_in1, data_in2, data_in3,
    input  data_in4, data_in5, data_in6, data_in7,
    input  bias, en, pos_idx, oc_idx
  );
endinterface

// File: rtl/pwconv_1point_mul8_issuer.sv
// Producer for the PWconv 1x1 point adder. Walks (pos, oc) with oc innermost,
// issues one feature word and one weight word per pair, and presents the
// 8 signed int8 products (sign-extended to 32 bits) plus the channel bias.
// feat_addr/w_addr are registered read addresses; the memory returns the
// addressed word in the cycle after the pair was issued, so the addresses
// double as the stage-1 tags. Everything freezes while out_ready is 0.
module pwconv_1point_mul8_issuer #(
  parameter int NPOS = 16,
  parameter int NOC  = 4,
  parameter int PA_W = 4,
  parameter int OA_W = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            start,
  output logic [PA_W-1:0] feat_addr,
  input  logic [63:0]     feat_data,
  output logic [OA_W-1:0] w_addr,
  input  logic [63:0]     w_data,
  input  logic [31:0]     bias_data,
  output logic            busy,
  output logic            done,
  output logic [1:0]      dbg_state,
  pwconv_1point_mul8_issuer_if.master pt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PA_W-1:0] POS_LAST = PA_W'(NPOS - 1);
  localparam logic [OA_W-1:0] OC_LAST  = OA_W'(NOC - 1);

  state_t          state_q, state_d;
  logic [PA_W-1:0] pos_q, pos_d;
  logic [OA_W-1:0] oc_q, oc_d;
  logic [PA_W-1:0] feat_addr_q, feat_addr_d;
  logic [OA_W-1:0] w_addr_q, w_addr_d;
  logic            v1_q, v1_d;
  logic            v2_q, v2_d;
  logic            en_q, en_d;
  logic [PA_W-1:0] pos_idx_q, pos_idx_d;
  logic [OA_W-1:0] oc_idx_q, oc_idx_d;
  logic [31:0]     bias_q, bias_d;
  logic [31:0]     data_q [8];
  logic [31:0]     data_d [8];

  logic            advance;
  logic            issue;
  logic            last_pair;
  logic signed [15:0] prod [8];

  assign advance   = pt.out_ready;
  assign issue     = (state_q == S_RUN) && advance;
  assign last_pair = (pos_q == POS_LAST) && (oc_q == OC_LAST);

  // Full signed 8x8 products, one per channel lane.
  for (genvar k = 0; k < 8; k++) begin : g_mul
    assign prod[k] = $signed(feat_data[8*k +: 8]) * $signed(w_data[8*k +: 8]);
  end

  // Next-state: pair counters, issue stage, output stage and FSM.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    oc_d        = oc_q;
    feat_addr_d = feat_addr_q;
    w_addr_d    = w_addr_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    en_d        = 1'b0;
    pos_idx_d   = pos_idx_q;
    oc_idx_d    = oc_idx_q;
    bias_d      = bias_q;
    for (int k = 0; k < 8; k++) begin
      data_d[k] = data_q[k];
    end

    // Stage 0: issue the current pair and step oc (inner) then pos (outer).
    if (issue) begin
      feat_addr_d = pos_q;
      w_addr_d    = oc_q;
      if (oc_q == OC_LAST) begin
        oc_d  = '0;
        pos_d = last_pair ? '0 : pos_q + 1'b1;
      end else begin
        oc_d  = oc_q + 1'b1;
      end
    end

    // Stages 1/2: memory data is valid while v1 is set; latch it on advance.
    if (advance) begin
      v1_d = issue;
      v2_d = v1_q;
      en_d = v1_q;
      if (v1_q) begin
        for (int k = 0; k < 8; k++) begin
          data_d[k] = {{16{prod[k][15]}}, prod[k]};
        end
        bias_d    = bias_data;
        pos_idx_d = feat_addr_q;
        oc_idx_d  = w_addr_q;
      end
    end

    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (issue && last_pair) state_d = S_DRAIN;
      S_DRAIN: if (!v1_d && !v2_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      oc_q        <= '0;
      feat_addr_q <= '0;
      w_addr_q    <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      en_q        <= 1'b0;
      pos_idx_q   <= '0;
      oc_idx_q    <= '0;
      bias_q      <= '0;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      oc_q        <= oc_d;
      feat_addr_q <= feat_addr_d;
      w_addr_q    <= w_addr_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      en_q        <= en_d;
      pos_idx_q   <= pos_idx_d;
      oc_idx_q    <= oc_idx_d;
      bias_q      <= bias_d;
      for (int k = 0; k < 8; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign feat_addr  = feat_addr_q;
  assign w_addr     = w_addr_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign dbg_state  = state_q;

  assign pt.data_in0 = data_q[0];
  assign pt.data_in1 = data_q[1];
  assign pt.data_in2 = data_q[2];
  assign pt.data_in3 = data_q[3];
  assign pt.data_in4 = data_q[4];
  assign pt.data_in5 = data_q[5];
  assign pt.data_in6 = data_q[6];
  assign pt.data_in7 = data_q[7];
  assign pt.bias     = bias_q;
  assign pt.en       = en_q;
  assign pt.pos_idx  = pos_idx_q;
  assign pt.oc_idx   = oc_idx_q;

endmodule
